// File: rtl/airi5c_fpu_issue_ctrl.sv
// airi5c_fpu_issue_ctrl: hands one FP operation at a time to the FPU core and keeps the sticky fflags.
// Optional watchdog on the core wait: AIRI5C_FPU_ISSUE_TIMEOUT_EN.
`default_nettype none

module airi5c_fpu_issue_ctrl #(
    parameter int OP_W        = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [2:0]      req_rm,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [2:0]      csr_frm,
    input  logic            csr_fflags_we,
    input  logic [4:0]      csr_fflags_wdata,
    output logic [4:0]      fflags,
    output logic            core_load,
    output logic            core_kill,
    output logic            core_op_add,
    output logic            core_op_sub,
    output logic            core_op_mul,
    output logic            core_op_div,
    output logic            core_op_sqrt,
    output logic            core_op_sgnj,
    output logic            core_op_sgnjn,
    output logic            core_op_sgnjx,
    output logic            core_op_cvtfi,
    output logic            core_op_cvtfu,
    output logic            core_op_cvtif,
    output logic            core_op_cvtuf,
    output logic            core_op_eq,
    output logic            core_op_lt,
    output logic            core_op_le,
    output logic            core_op_class,
    output logic            core_op_min,
    output logic            core_op_max,
    output logic [2:0]      core_rm,
    output logic [31:0]     core_a,
    output logic [31:0]     core_b,
    input  logic [31:0]     core_result,
    input  logic            core_IV,
    input  logic            core_DZ,
    input  logic            core_OF,
    input  logic            core_UF,
    input  logic            core_IE,
    input  logic            core_ready,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_result,
    output logic [4:0]      resp_flags,
    output logic            resp_illegal,
    output logic            busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [OP_W-1:0] op_q;
    logic [2:0]      rm_res;
    logic            accept, illegal, capture, timeout;
    logic [4:0]      core_flags;
    logic [17:0]     op_vec;

    assign rm_res     = (req_rm == 3'b111) ? csr_frm : req_rm;
    assign illegal    = (req_op >= OP_W'(18)) || (rm_res >= 3'd5);
    assign accept     = (state == S_IDLE) && req_valid && !flush;
    assign capture    = (state == S_WAIT) && core_ready && !flush;
    assign core_flags = {core_IV, core_DZ, core_OF, core_UF, core_IE};

`ifdef AIRI5C_FPU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already completed
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            wait_cnt <= '0;
        else if (state != S_WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == S_WAIT) && !core_ready && !flush &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout            = 1'b0;
`endif

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign core_load  = (state == S_ISSUE);
    assign core_kill  = flush || timeout;

    always_comb begin
        op_vec = '0;
        if (state == S_ISSUE || state == S_WAIT)
            op_vec = 18'(1) << op_q;
    end

    assign {core_op_max, core_op_min, core_op_class, core_op_le, core_op_lt, core_op_eq,
            core_op_cvtuf, core_op_cvtif, core_op_cvtfu, core_op_cvtfi, core_op_sgnjx,
            core_op_sgnjn, core_op_sgnj, core_op_sqrt, core_op_div, core_op_mul,
            core_op_sub, core_op_add} = op_vec;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (req_valid) state_nxt = illegal ? S_RESP : S_ISSUE;
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT:  if (core_ready || timeout) state_nxt = S_RESP;
                default: if (resp_ready) state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            core_rm      <= '0;
            core_a       <= '0;
            core_b       <= '0;
            resp_result  <= '0;
            resp_flags   <= '0;
            resp_illegal <= 1'b0;
            fflags       <= '0;
        end else begin
            state <= state_nxt;
            if (accept && illegal) begin
                resp_result  <= '0;
                resp_flags   <= '0;
                resp_illegal <= 1'b1;
            end else if (accept) begin
                op_q    <= req_op;
                core_rm <= rm_res;
                core_a  <= req_a;
                core_b  <= req_b;
            end
            if (capture) begin
                resp_result  <= core_result;
                resp_flags   <= core_flags;
                resp_illegal <= 1'b0;
            end else if (timeout) begin
                resp_result  <= 32'h7FC00000;
                resp_flags   <= 5'b10000;
                resp_illegal <= 1'b0;
            end
            // a CSR write replaces the accumulator but never masks a same-cycle capture
            fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags)
                    | (capture ? core_flags : 5'b0)
                    | (timeout ? 5'b10000 : 5'b0);
        end
    end

endmodule

`default_nettype wire
